// File: rtl/buffer_io_control_pkg.sv
// Shared sizes and descriptor field layout for the double-banked frame buffer.
package buffer_io_control_pkg;
   localparam int DATA_WORDS = 8192;
   localparam int HDR_WORDS  = 6;
   localparam int DESC_DEPTH = 16;

   localparam int WORD_W  = 16;
   localparam int DATA_AW = 13;   // 16-bit write-side address
   localparam int RD_AW   = 12;   // 32-bit read-side address
   localparam int DESC_AW = 4;
   localparam int DESC_W  = 48;
   localparam int FCNT_W  = 14;   // frame word counter, 0..HDR_WORDS+DATA_WORDS-1

   localparam int FIELD_W   = 16;
   localparam int START_LSB = 32;
   localparam int END_LSB   = 16;
   localparam int RSVD_LSB  = 0;
endpackage

// File: rtl/buffer_io_control_desc_ram.sv
// Descriptor RAM: sync write, async read at the write address, registered read at DPRA.
module desc_ram
   import buffer_io_control_pkg::*;
#(
   parameter int DEPTH = DESC_DEPTH
) (
   input  logic               clk,
   input  logic               we,
   input  logic [DESC_AW-1:0] a,
   input  logic [DESC_W-1:0]  d,
   input  logic [DESC_AW-1:0] dpra,
   output logic [DESC_W-1:0]  qspo,
   output logic [DESC_W-1:0]  qdpo
);
   logic [DESC_W-1:0] mem [DEPTH];
   logic [DESC_W-1:0] qdpo_q;

   always_ff @(posedge clk) begin
      if (we) mem[a] <= d;
   end

   always_ff @(posedge clk) begin
      qdpo_q <= mem[dpra];
   end

   assign qspo = mem[a];
   assign qdpo = qdpo_q;
endmodule

// File: rtl/buffer_io_control.sv
// Ping-pong frame buffer: input side fills the inactive bank with header+data,
// output side loops samples start..end of the active bank with a 2-cycle read pipe.
module buffer_io_control #(
   parameter int DATA_WORDS = buffer_io_control_pkg::DATA_WORDS,
   parameter int HDR_WORDS  = buffer_io_control_pkg::HDR_WORDS,
   parameter int DESC_DEPTH = buffer_io_control_pkg::DESC_DEPTH
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        active_buffer,
   input  logic        wen,
   input  logic [15:0] din,
   input  logic        ren,
   output logic [15:0] dout,
   output logic        ready
);
   import buffer_io_control_pkg::*;

   localparam int RD_DEPTH = DATA_WORDS / 2;
   localparam logic [FCNT_W-1:0] HDR_CNT  = FCNT_W'(HDR_WORDS);
   localparam logic [FCNT_W-1:0] LAST_CNT = FCNT_W'(HDR_WORDS + DATA_WORDS - 1);

   logic                ab_q, ren_q;
   logic                ab_chg, wr_bank;
   logic [FCNT_W-1:0]   fcnt_q, fcnt_d, fcnt_base;
   logic [1:0]          hpos_q, hpos_d, hpos_base;
   logic [DESC_AW-1:0]  hidx_q, hidx_d, hidx_base;
   logic [WORD_W-1:0]   w0_q, w0_d, w1_q, w1_d;
   logic                ready_q, ready_d;
   logic                desc_we, dram_we;
   logic [DATA_AW-1:0]  dram_wa;
   logic [DESC_W-1:0]   desc_wd;
   logic [1:0][DESC_W-1:0] qspo, qdpo;

   assign ab_chg  = active_buffer != ab_q;
   assign wr_bank = ~active_buffer;
   assign desc_wd = {w0_q, w1_q, din};

   // ---------------- input side ----------------
   // A bank swap abandons the frame; a word arriving on that same edge starts a new one.
   always_comb begin
      fcnt_base = ab_chg ? '0 : fcnt_q;
      hpos_base = ab_chg ? '0 : hpos_q;
      hidx_base = ab_chg ? '0 : hidx_q;
      fcnt_d    = fcnt_base;
      hpos_d    = hpos_base;
      hidx_d    = hidx_base;
      w0_d      = w0_q;
      w1_d      = w1_q;
      ready_d   = ready_q & ~ab_chg;
      desc_we   = 1'b0;
      dram_we   = 1'b0;
      dram_wa   = DATA_AW'(fcnt_base - HDR_CNT);
      if (wen) begin
         ready_d = 1'b0;
         if (fcnt_base < HDR_CNT) begin
            case (hpos_base)
               2'd0:    w0_d    = din;
               2'd1:    w1_d    = din;
               default: desc_we = 1'b1;
            endcase
            hpos_d = (hpos_base == 2'd2) ? 2'd0 : hpos_base + 2'd1;
            hidx_d = (hpos_base == 2'd2) ? hidx_base + DESC_AW'(1) : hidx_base;
         end else begin
            dram_we = 1'b1;
         end
         if (fcnt_base == LAST_CNT) begin
            fcnt_d  = '0;
            hpos_d  = '0;
            hidx_d  = '0;
            ready_d = 1'b1;
         end else begin
            fcnt_d  = fcnt_base + FCNT_W'(1);
         end
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_desc
      desc_ram #(.DEPTH(DESC_DEPTH)) u_desc (
         .clk  (clk),
         .we   (desc_we && (wr_bank == 1'(b))),
         .a    (hidx_base),
         .d    (desc_wd),
         .dpra (DESC_AW'(0)),
         .qspo (qspo[b]),
         .qdpo (qdpo[b])
      );
   end

   // ---------------- data RAMs (16-bit write, 32-bit read, read-first) ----------------
   logic [1:0][WORD_W-1:0] mem0 [RD_DEPTH];
   logic [1:0][WORD_W-1:0] mem1 [RD_DEPTH];
   logic [1:0][WORD_W-1:0] rdat_q;
   logic [RD_AW-1:0]       rd_addr;

   always_ff @(posedge clk) begin
      if (dram_we && !wr_bank) mem0[dram_wa[DATA_AW-1:1]][dram_wa[0]] <= din;
      if (dram_we &&  wr_bank) mem1[dram_wa[DATA_AW-1:1]][dram_wa[0]] <= din;
   end

   always_ff @(posedge clk) begin
      rdat_q <= active_buffer ? mem1[rd_addr] : mem0[rd_addr];
   end

   // ---------------- output side ----------------
   logic [DESC_W-1:0]  desc_act;
   logic [DATA_AW-1:0] start_idx, end_idx;
   logic [DATA_AW-1:0] ptr_q, ptr_d;
   logic               load;
   logic               half_q, half_d, vld_q, vld_d;
   logic [WORD_W-1:0]  dout_q, dout_d;

   assign desc_act  = qdpo[active_buffer];
   assign start_idx = desc_act[START_LSB +: DATA_AW];
   assign end_idx   = desc_act[END_LSB +: DATA_AW];
   assign load      = ren & (~ren_q | ab_chg);

   // ptr_d is the pointer issued this cycle; natural 13-bit rollover covers end < start.
   always_comb begin
      ptr_d = ptr_q;
      if (load)      ptr_d = start_idx;
      else if (ren)  ptr_d = (ptr_q == end_idx) ? start_idx : ptr_q + DATA_AW'(1);
      rd_addr = ptr_d[DATA_AW-1:1];
      half_d  = ptr_d[0];
      vld_d   = ren;
      dout_d  = vld_q ? rdat_q[half_q] : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ab_q    <= 1'b0;
         ren_q   <= 1'b0;
         fcnt_q  <= '0;
         hpos_q  <= '0;
         hidx_q  <= '0;
         w0_q    <= '0;
         w1_q    <= '0;
         ready_q <= 1'b0;
         ptr_q   <= '0;
         half_q  <= 1'b0;
         vld_q   <= 1'b0;
         dout_q  <= '0;
      end else begin
         ab_q    <= active_buffer;
         ren_q   <= ren;
         fcnt_q  <= fcnt_d;
         hpos_q  <= hpos_d;
         hidx_q  <= hidx_d;
         w0_q    <= w0_d;
         w1_q    <= w1_d;
         ready_q <= ready_d;
         ptr_q   <= ptr_d;
         half_q  <= half_d;
         vld_q   <= vld_d;
         dout_q  <= dout_d;
      end
   end

   assign dout  = dout_q;
   assign ready = ready_q;

   logic unused_bits;
   assign unused_bits = ^{qspo, desc_act};
endmodule

// File: tb/tb_buffer_io_control.sv
// Directed + randomized bench for buffer_io_control against a frame-level reference model.
module tb_buffer_io_control;
   logic        clk, rst, ab, wen, ren;
   logic [15:0] din;
   logic [15:0] dout;
   logic        ready;

   buffer_io_control dut (
      .clk(clk), .rst(rst), .active_buffer(ab), .wen(wen), .din(din),
      .ren(ren), .dout(dout), .ready(ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0, passes = 0, fails = 0;

   // reference model: whole-bank contents plus frame position and playback pointer
   logic [15:0] mdata [2][8192];
   logic [47:0] mdesc [2][2];
   logic [15:0] hw [6];
   int          fpos, mptr;
   bit          mready, ren_prev, ab_prev;
   logic [15:0] pipe, mdout;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      fpos = 0; mready = 0; mptr = 0; pipe = '0; mdout = '0;
      ren_prev = 0; ab_prev = 0;
   endtask

   task automatic tick();
      bit chg, load;
      int st, en, wb;
      logic [15:0] smp;
      chg  = (ab != ab_prev);
      st   = int'(mdesc[ab][0][47:32]) % 8192;
      en   = int'(mdesc[ab][0][31:16]) % 8192;
      load = ren && (!ren_prev || chg);
      if (load)     mptr = st;
      else if (ren) mptr = (mptr == en) ? st : (mptr + 1) % 8192;
      smp   = ren ? mdata[ab][mptr] : 16'h0;
      mdout = pipe;
      pipe  = smp;
      if (chg) begin fpos = 0; mready = 0; end
      if (wen) begin
         wb = ab ? 0 : 1;
         mready = 0;
         if (fpos < 6) begin
            hw[fpos] = din;
            if (fpos == 2) mdesc[wb][0] = {hw[0], hw[1], hw[2]};
            if (fpos == 5) mdesc[wb][1] = {hw[3], hw[4], hw[5]};
         end else begin
            mdata[wb][fpos-6] = din;
         end
         if (fpos == 8197) begin fpos = 0; mready = 1; end
         else fpos++;
      end
      ren_prev = ren;
      ab_prev  = ab;
      @(posedge clk); #1;
      check("dout", dout, mdout);
      check("ready", {15'h0, ready}, {15'h0, mready});
   endtask

   task automatic send_word(input logic [15:0] w);
      wen = 1'b1; din = w;
      tick();
      wen = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] s, input logic [15:0] e, input bit rnd);
      logic [15:0] w;
      for (int i = 0; i < 6; i++) begin
         w = (i == 0) ? s : (i == 1) ? e : (rnd ? 16'($urandom) : 16'h0);
         send_word(w);
      end
      for (int n = 0; n < 8192; n++) begin
         w = rnd ? 16'($urandom) : 16'(32'h1000 + n);
         send_word(w);
      end
      check("ready_eof", {15'h0, ready}, 16'h1);
   endtask

   logic [15:0] seq [5];

   initial begin
      rst = 1'b1; ab = 1'b0; wen = 1'b0; ren = 1'b0; din = '0;
      model_reset();
      #2;
      check("reset_dout", dout, 16'h0);
      check("reset_ready", {15'h0, ready}, 16'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // reset asserted while word 100 is on the bus
      for (int i = 0; i < 100; i++) send_word(16'($urandom));
      wen = 1'b1; din = 16'hBEEF;
      rst = 1'b1;
      #2;
      check("midrst_dout", dout, 16'h0);
      check("midrst_ready", {15'h0, ready}, 16'h0);
      wen = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();

      // full frame into bank 1, play 0x1000..0x1007
      send_frame(16'd0, 16'd7, 1'b0);
      tick();
      check("ready_hold", {15'h0, ready}, 16'h1);
      ab = 1'b1;
      tick();
      check("ready_clr_swap", {15'h0, ready}, 16'h0);
      ren = 1'b1;
      tick();
      tick();
      check("first_sample", dout, 16'h1000);
      repeat (30) tick();
      ren = 1'b0;
      repeat (3) tick();
      ren = 1'b1;
      tick();
      tick();
      check("restart_sample", dout, 16'h1000);
      repeat (10) tick();

      // wrap-around window 8190..1, written while bank 1 keeps playing
      send_frame(16'd8190, 16'd1, 1'b0);
      tick();
      ab = 1'b0;
      tick();
      seq[0] = 16'h2FFE; seq[1] = 16'h2FFF; seq[2] = 16'h1000; seq[3] = 16'h1001; seq[4] = 16'h2FFE;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("wrap_seq", dout, seq[k]);
      end

      // two back-to-back random frames into bank 1, then play them
      send_frame(16'($urandom), 16'($urandom), 1'b1);
      send_frame(16'($urandom), 16'($urandom), 1'b1);
      tick();
      ab = 1'b1;
      repeat (40) tick();

      // abandon a frame after word 3000, then a new header into the new inactive bank
      for (int i = 0; i < 3001; i++) send_word(16'($urandom));
      ab = 1'b0;
      tick();
      check("ready_partial", {15'h0, ready}, 16'h0);
      send_word(16'd2);
      send_word(16'd5);
      for (int i = 0; i < 4; i++) send_word(16'h0);
      tick();
      ab = 1'b1;
      tick();
      tick();
      check("new_hdr_start", dout, mdata[1][2]);
      repeat (12) tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/buffer_io_control.md
BUFFER_IO_CONTROL -- requirements
Module: buffer_io_control

Interface
REQ-001 SHALL expose parameters: DATA_WORDS, default 8192, 16-bit data words per frame; HDR_WORDS, default 6, header words per frame (3 per descriptor); DESC_DEPTH, default 16, descriptor RAM entries.
REQ-002 SHALL use one clock; reset is asynchronous and active-high.
REQ-003 SHALL have these ports, in this order:
- clk: input, 1 bit, clock; all logic on the rising edge.
- rst: input, 1 bit, asynchronous active-high reset.
- active_buffer: input, 1 bit, bank being played out; the input side writes the other bank.
- wen: input, 1 bit, input word valid.
- din: input, 16 bits, input word.
- ren: input, 1 bit, playback enable.
- dout: output, 16 bits, playback sample.
- ready: output, 1 bit, a complete frame has been written to the inactive bank.

Function
REQ-004 SHALL contain two banks (0,1), each holding a data RAM (8192x16 write side / 4096x32 read side) and a descriptor RAM (16x48).
REQ-005 Frame layout: words 0..5 are header, words 6..8197 are data.
REQ-006 Input writes bank (~active_buffer); an input word is accepted on any clock edge where wen=1.
REQ-007 Header words: three consecutive words w0,w1,w2 SHALL be written as descriptor k={w0,w1,w2} (w0 in [47:32]) at descriptor address k, on the cycle w2 is accepted; k=0,1.
REQ-008 Data word n (n=0..8191) SHALL be written to data RAM write address n.
REQ-009 Data RAM packing: a 32-bit read word at address m = {word 2m+1, word 2m}, with the even word in [15:0].
REQ-010 Frame counter: after word 8197 it SHALL wrap to 0, so the next accepted word is a new header word 0.
REQ-011 ready SHALL go 1 the cycle after word 8197 is written, and go 0 when the next word is accepted or when active_buffer changes.
REQ-012 Any change of active_buffer SHALL reset the frame counter to 0; a partial frame is abandoned.
REQ-013 Output reads bank active_buffer. Descriptor 0 of that bank is used as: [47:32]=start index, [31:16]=end index (low 13 bits used), [15:0]=reserved. Descriptor 1 is stored but unused.
REQ-014 Sample pointer ptr (13 bit):
- Loaded with start when ren rises, or when active_buffer changes while ren=1.
- Otherwise, while ren=1, advances by 1 each cycle.
- After end it returns to start.
- If end<start, it wraps 8191->0 and continues to end.
REQ-015 Each cycle: data read address = ptr[12:1]; the selected half (ptr[0]=0 gives [15:0]) is registered to dout. dout SHALL present sample ptr exactly 2 cycles after ptr is issued.
REQ-016 When ren=0, dout SHALL read 0 starting 2 cycles after ren falls; ptr holds its value.
REQ-017 Simultaneous input write and output read on the same RAM: the RAMs are read-first. Since the banks differ, this happens only through an active_buffer change, and the read returns the old data.

Reset
REQ-018 On rst=1, immediately:
- dout=0, ready=0.
- Frame counter=0, ptr=0, read pipeline cleared.
- RAM contents are not cleared.
REQ-019 After rst is released, the first accepted word SHALL be header word 0.

Structure
REQ-020 A shared package SHALL hold DATA_WORDS, HDR_WORDS, DESC_DEPTH, the address widths (13/12/4) and the descriptor field bit positions.
REQ-021 Sub-module desc_ram:
- 16x48 RAM.
- Synchronous write (A, D, WE).
- Asynchronous read port QSPO at A.
- Registered read port QDPO at DPRA.
- Instantiated twice.
REQ-022 Data RAMs SHALL be inferred behaviourally inside the block; input and output control are separate always-block groups.

Verification
REQ-023 Reset mid-stream: assert rst during word 100 -> dout=0 and ready=0 at once; after release, the first word is treated as header 0.
REQ-024 Full frame with active_buffer=0: header {0,7,0,0,0,0}, data 0x1000+n -> ready=1 after word 8197. Then toggle active_buffer to 1 and raise ren -> dout plays 0x1000..0x1007 repeatedly, first sample 2 cycles after ren rises.
REQ-025 Header start=8190, end=1 -> dout sequence 0x1000+8190, 0x1000+8191, 0x1000, 0x1001, then repeats.
REQ-026 Toggle active_buffer after word 3000 of a frame -> ready stays 0; the next word is written as header word 0 into the new inactive bank.
REQ-027 Two back-to-back frames with wen held high -> ready pulses for 1 cycle after each word 8197; second-frame header words land at descriptor 0/1 again.
REQ-028 Drop ren for 3 cycles during playback -> dout=0 for those cycles (2-cycle delayed); on ren rise, playback restarts at start.
